// File: rtl/uart_tx_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param_pkg
//  Purpose  : Shared definitions for the parametrised UART transmitter:
//             parity-mode encodings, FSM state encoding and parity helpers.
//  Contents : PAR_NONE / PAR_EVEN / PAR_ODD / PAR_NONE_ALT, tx_state_e,
//             mode_has_parity(), parity_bit()
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_param_pkg;

   // Parity-mode field as written by the CPU register block.
   // Encoding 2'b11 is reserved and behaves as "no parity".
   localparam logic [1:0] PAR_NONE     = 2'b00;
   localparam logic [1:0] PAR_EVEN     = 2'b01;
   localparam logic [1:0] PAR_ODD      = 2'b10;
   localparam logic [1:0] PAR_NONE_ALT = 2'b11;

   // Transmit FSM states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // True when the mode inserts a parity bit into the frame.
   function automatic logic mode_has_parity(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Parity bit over up to 9 data bits. Callers zero-extend narrower words,
   // which leaves the XOR reduction unchanged.
   function automatic logic parity_bit(input logic       odd_sel,
                                       input logic [8:0] data);
      return odd_sel ? ~(^data) : (^data);
   endfunction

endpackage : uart_tx_param_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Synchronous FIFO buffering words ahead of the UART transmitter.
//             A push into a full FIFO is ignored; a pop of an empty FIFO is
//             ignored; simultaneous push and pop leave the level unchanged.
//  Ports    : clk      in   system clock, rising edge
//             rst      in   asynchronous reset, active-low (flushes FIFO)
//             push_i   in   write wdata_i this edge (if not full)
//             wdata_i  in   WIDTH-bit write data
//             pop_i    in   discard head entry this edge (if not empty)
//             rdata_o  out  head entry (valid when !empty_o)
//             full_o   out  FIFO holds DEPTH entries
//             empty_o  out  FIFO holds no entries
//             level_o  out  number of entries held
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q,  level_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i  && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: the flushed pointers make stale words unreachable.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_param
//  Purpose  : Parametrised UART transmitter with input FIFO. Frame format:
//             start bit, DATA_BITS data bits LSB first, optional even/odd
//             parity bit, 1 or 2 stop bits. Frames run back to back while the
//             FIFO holds data. Frame format is latched when a word is loaded.
//  Ports    : clk          in   system clock, rising edge
//             rst          in   asynchronous reset, active-low
//             tx_data      in   word to send
//             tx_valid     in   tx_data valid this cycle
//             tx_ready     out  FIFO can accept (low while in reset)
//             parity_mode  in   00 none, 01 even, 10 odd, 11 none
//             stop2        in   1 = two stop bits
//             tx           out  serial line, idle high, registered
//             tx_busy      out  frame in progress or FIFO not empty
//             tx_done      out  one-cycle pulse on the last cycle of a frame
//             fifo_level   out  entries currently held in the FIFO
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_param
   import uart_tx_param_pkg::*;
#(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop2,
   output logic                          tx,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV    = CLK_FREQ / BAUD;
   localparam int BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] DIV_LAST = BAUD_W'(DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
      end
      if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
         $error("uart_tx_param: DATA_BITS must be in 5..9");
      end
   endgenerate

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [DATA_BITS-1:0]  fifo_rdata;
   logic                  fifo_full;
   logic                  fifo_empty;

   // Gating with rst keeps tx_ready low for the whole reset period.
   assign tx_ready  = rst && !fifo_full;
   assign fifo_push = tx_valid && tx_ready;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i (tx_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   tx_state_e             state_q,  state_d;
   logic [BAUD_W-1:0]     baud_q,   baud_d;
   logic [BIT_W-1:0]      bit_q,    bit_d;     // data bit index, stop bit index in STOP
   logic [DATA_BITS-1:0]  shift_q,  shift_d;
   logic                  par_en_q, par_en_d;
   logic                  par_q,    par_d;     // parity bit precomputed at load
   logic                  stop2_q,  stop2_d;
   logic                  tx_q,     tx_d;
   logic                  baud_tick;
   logic                  load;
   logic                  frame_end;

   assign baud_tick = (baud_q == DIV_LAST);

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_en_d  = par_en_q;
      par_d     = par_q;
      stop2_d   = stop2_q;
      tx_d      = tx_q;
      load      = 1'b0;
      frame_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!fifo_empty) begin
               load = 1'b1;
            end
         end

         ST_START: begin
            if (baud_tick) begin
               state_d = ST_DATA;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end

         ST_DATA: begin
            if (baud_tick) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
                  // Next bit is the one about to reach position 0.
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         ST_PARITY: begin
            if (baud_tick) begin
               state_d = ST_STOP;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b1;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end

         ST_STOP: begin
            tx_d = 1'b1;
            if (baud_tick) begin
               baud_d = '0;
               if (stop2_q && (bit_q == '0)) begin
                  bit_d = BIT_W'(1);
               end else begin
                  // Last cycle of the frame; chain straight into the next one.
                  frame_end = 1'b1;
                  bit_d     = '0;
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
         end
      endcase

      // Frame load: format inputs are sampled here only, so later changes
      // cannot disturb a frame already in flight.
      if (load) begin
         state_d  = ST_START;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = fifo_rdata;
         par_en_d = mode_has_parity(parity_mode);
         par_d    = parity_bit(parity_mode == PAR_ODD, 9'(fifo_rdata));
         stop2_d  = stop2;
         tx_d     = 1'b0;
      end
      fifo_pop = load;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         stop2_q  <= stop2_d;
         tx_q     <= tx_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = frame_end;
   assign tx_busy = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule : uart_tx_param
`default_nettype wire
